ad7606_emu: RTL and testbench
=============================

AD7606_EMU -- requirements
Module: ad7606_emu

Interface
REQ-001 SHALL have parameter CONV_CYCLES, default 200: base BUSY duration in clk cycles (1..65535).
REQ-002 SHALL have parameter NUM_CH, default 8: number of channels; fixed at 8 for this block.
REQ-003 SHALL have port clk  in  1  system clock; all other inputs are synchronous to it.
REQ-004 SHALL have port rst_n  in  1  reset, asynchronous, active-low.
REQ-005 SHALL have port adc_rst  in  1  device RESET pin, active-high, synchronous.
REQ-006 SHALL have port convst  in  1  conversion start; the rising edge starts a conversion.
REQ-007 SHALL have port cs_n  in  1  chip select, active-low.
REQ-008 SHALL have port rd_n  in  1  read strobe, active-low.
REQ-009 SHALL have port os  in  3  oversampling ratio code.
REQ-010 SHALL have port smp_wr  in  1  write strobe for the shadow sample registers.
REQ-011 SHALL have port smp_ch  in  3  shadow register index (0 = channel 1).
REQ-012 SHALL have port smp_data  in  16  shadow sample value.
REQ-013 SHALL have port busy  out  1  conversion in progress.
REQ-014 SHALL have port frstdata  out  1  high while db carries channel 1.
REQ-015 SHALL have port db  out  16  parallel data output.
REQ-016 SHALL have port db_oe  out  1  data bus drive enable, equal to ~cs_n & ~rd_n (combinational).
REQ-017 SHALL have port conv_ignored  out  1  one-cycle pulse when a convst edge is rejected.

Function
REQ-018 SHALL detect convst and rd_n edges using one-cycle delayed copies; no extra synchronizer stages.
REQ-019 SHALL write smp_data into shadow[smp_ch] on any cycle with smp_wr=1, in every state.
REQ-020 SHALL implement states: IDLE, CONV and READY.
REQ-021 On a convst rising edge in IDLE or READY, SHALL copy all 8 shadow registers into the result registers in that cycle.
REQ-021a If smp_wr is active in that same cycle, SHALL capture the old shadow value.
REQ-022 On that same edge SHALL enter CONV, assert busy on the next clk, reset the read pointer to 0 and load the timer.
REQ-023 BUSY duration SHALL be CONV_CYCLES << os for os=1..6; os=0 and os=7 SHALL both use CONV_CYCLES.
REQ-024 The timer SHALL be 24 bits wide so the maximum duration (65535<<6) does not overflow.
REQ-025 When the timer expires, SHALL deassert busy and enter READY.
REQ-026 A convst rising edge during CONV SHALL be ignored and SHALL pulse conv_ignored for 1 cycle; busy timing SHALL be unaffected.
REQ-027 In READY, an rd_n falling edge with cs_n=0 SHALL drive result[ptr] onto db on the next cycle and then increment ptr.
REQ-027a frstdata SHALL equal (ptr==0) at that read.
REQ-028 ptr SHALL wrap from 7 to 0, so the 9th read returns channel 1 with frstdata=1.
REQ-029 An rd_n falling edge with cs_n=1, or in IDLE/CONV, SHALL NOT change db, frstdata or ptr.
REQ-030 db and frstdata SHALL hold their last value between reads.
REQ-031 adc_rst=1 SHALL force IDLE and clear busy, frstdata, db, ptr, timer and result registers in the next cycle, aborting any conversion in progress.
REQ-031a adc_rst=1 SHALL leave the shadow registers unchanged.
REQ-032 While adc_rst=1, convst and read edges SHALL be ignored.
REQ-033 A convst edge coincident with adc_rst=1 SHALL be dropped, and conv_ignored SHALL NOT pulse.

Reset
REQ-034 rst_n=0 SHALL asynchronously set: state=IDLE, busy=0, frstdata=0, db=16'h0000, conv_ignored=0, ptr=0, timer=0, and all shadow/result registers = 16'h0000.
REQ-034a The edge-detect delay registers SHALL reset to the idle pin levels: convst=0, rd_n=1.

Structure
REQ-035 Package ad7606_pkg SHALL hold the state enum, NUM_CH=8, the timer width (24) and the os-to-shift decode function.
REQ-036 The BUSY timer SHALL be the sub-module ad7606_emu_timer (inputs: load, duration; output: expired pulse; clear on adc_rst).

Verification
REQ-037 Scenario: load shadow 0x1111..0x8888, os=0, CONV_CYCLES=200, convst pulse. Required response: busy high exactly 200 cycles; 8 reads (rd_n low 4 cycles) return 0x1111..0x8888; frstdata=1 only on the first read.
REQ-038 Scenario: os=2 and os=7 conversions. Required response: busy lasts 800 and 200 cycles respectively.
REQ-039 Scenario: second convst 50 cycles into CONV. Required response: conv_ignored pulses once and busy still falls at cycle 200.
REQ-040 Scenario: overwrite shadow ch1 to 0xABCD during CONV. Required response: the read returns the old value; the next conversion returns 0xABCD.
REQ-041 Scenario: 9 reads after one conversion, plus reads with cs_n=1. Required response: the 9th read gives ch1 with frstdata=1; cs_n=1 reads leave db unchanged and db_oe=0.
REQ-042 Scenario: adc_rst pulse at cycle 100 of CONV. Required response: busy=0 the next cycle, state IDLE, db=0x0000; a following convst converts normally.

Source files
------------

// File: rtl/ad7606_pkg.sv
// rtl/ad7606_pkg.sv - shared types, sizes and oversampling decode for the AD7606 emulator
package ad7606_pkg;

    localparam int NUM_CH  = 8;
    localparam int TIMER_W = 24;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_CONV,
        ST_READY
    } state_t;

    // Codes 0 and 7 both mean "no oversampling".
    function automatic logic [2:0] os_shift(input logic [2:0] os);
        return (os == 3'd0 || os == 3'd7) ? 3'd0 : os;
    endfunction

endpackage

// File: rtl/ad7606_emu_if.sv
// rtl/ad7606_emu_if.sv - AD7606 pin bundle plus shadow sample write port
interface ad7606_emu_if;

    logic        adc_rst;
    logic        convst;
    logic        cs_n;
    logic        rd_n;
    logic [2:0]  os;
    logic        smp_wr;
    logic [2:0]  smp_ch;
    logic [15:0] smp_data;
    logic        busy;
    logic        frstdata;
    logic [15:0] db;
    logic        db_oe;
    logic        conv_ignored;

    modport master (
        output adc_rst, convst, cs_n, rd_n, os, smp_wr, smp_ch, smp_data,
        input  busy, frstdata, db, db_oe, conv_ignored
    );

    modport slave (
        input  adc_rst, convst, cs_n, rd_n, os, smp_wr, smp_ch, smp_data,
        output busy, frstdata, db, db_oe, conv_ignored
    );

endinterface

// File: rtl/ad7606_emu_timer.sv
// rtl/ad7606_emu_timer.sv - BUSY down-counter, one-cycle expired pulse at the end of the duration
module ad7606_emu_timer
    import ad7606_pkg::*;
(
    input  logic               clk,
    input  logic               rst_n,
    input  logic               clr,
    input  logic               load,
    input  logic [TIMER_W-1:0] duration,
    output logic               expired
);

    logic [TIMER_W-1:0] count;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
        end else if (clr) begin
            count <= '0;
        end else if (load) begin
            count <= duration;
        end else if (count != '0) begin
            count <= count - 1'b1;
        end
    end

    // Firing on the last loaded count makes busy span exactly `duration` cycles.
    assign expired = (count == TIMER_W'(1)) && !clr;

endmodule

// File: rtl/ad7606_emu.sv
// rtl/ad7606_emu.sv - AD7606 parallel-interface ADC emulator with shadow sample registers
module ad7606_emu
    import ad7606_pkg::state_t, ad7606_pkg::ST_IDLE, ad7606_pkg::ST_CONV,
           ad7606_pkg::ST_READY, ad7606_pkg::TIMER_W, ad7606_pkg::os_shift;
#(
    parameter int CONV_CYCLES = 200,
    parameter int NUM_CH      = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    ad7606_emu_if.slave  bus
);

    state_t              state;
    state_t              state_next;
    logic                convst_d;
    logic                rd_n_d;
    logic                conv_edge;
    logic                rd_fall;
    logic                start_conv;
    logic                do_read;
    logic                ign_pulse;
    logic                timer_expired;
    logic [2:0]          ptr;
    logic [15:0]         shadow [NUM_CH];
    logic [15:0]         result [NUM_CH];
    logic [TIMER_W-1:0]  duration;

    assign conv_edge = bus.convst & ~convst_d;
    assign rd_fall   = ~bus.rd_n & rd_n_d;
    assign duration  = TIMER_W'(CONV_CYCLES) << os_shift(bus.os);
    assign bus.db_oe = ~bus.cs_n & ~bus.rd_n;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        start_conv = 1'b0;
        do_read    = 1'b0;
        ign_pulse  = 1'b0;
        if (bus.adc_rst) begin
            state_next = ST_IDLE;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (conv_edge) begin
                        start_conv = 1'b1;
                        state_next = ST_CONV;
                    end
                end
                ST_CONV: begin
                    ign_pulse = conv_edge;
                    if (timer_expired) begin
                        state_next = ST_READY;
                    end
                end
                ST_READY: begin
                    if (conv_edge) begin
                        start_conv = 1'b1;
                        state_next = ST_CONV;
                    end else if (rd_fall && !bus.cs_n) begin
                        do_read = 1'b1;
                    end
                end
                default: state_next = ST_IDLE;
            endcase
        end
    end

    // Edge detectors idle at the pin rest levels so reset itself never looks like an edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            convst_d <= 1'b0;
            rd_n_d   <= 1'b1;
        end else begin
            convst_d <= bus.convst;
            rd_n_d   <= bus.rd_n;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NUM_CH; i++) begin
                shadow[i] <= 16'h0000;
            end
        end else if (bus.smp_wr) begin
            shadow[bus.smp_ch] <= bus.smp_data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bus.busy         <= 1'b0;
            bus.frstdata     <= 1'b0;
            bus.db           <= 16'h0000;
            bus.conv_ignored <= 1'b0;
            ptr              <= 3'd0;
            for (int i = 0; i < NUM_CH; i++) begin
                result[i] <= 16'h0000;
            end
        end else begin
            bus.busy         <= (state_next == ST_CONV);
            bus.conv_ignored <= ign_pulse;
            if (bus.adc_rst) begin
                bus.frstdata <= 1'b0;
                bus.db       <= 16'h0000;
                ptr          <= 3'd0;
                for (int i = 0; i < NUM_CH; i++) begin
                    result[i] <= 16'h0000;
                end
            end else if (start_conv) begin
                ptr <= 3'd0;
                // Non-blocking copy takes the pre-write shadow value if smp_wr coincides.
                for (int i = 0; i < NUM_CH; i++) begin
                    result[i] <= shadow[i];
                end
            end else if (do_read) begin
                bus.db       <= result[ptr];
                bus.frstdata <= (ptr == 3'd0);
                ptr          <= ptr + 3'd1;
            end
        end
    end

    ad7606_emu_timer u_timer (
        .clk      (clk),
        .rst_n    (rst_n),
        .clr      (bus.adc_rst),
        .load     (start_conv),
        .duration (duration),
        .expired  (timer_expired)
    );

endmodule

// File: tb/tb_ad7606_emu.sv
// tb/tb_ad7606_emu.sv - scoreboard bench for the AD7606 emulator
module tb_ad7606_emu;

    typedef struct packed {
        logic [15:0] db;
        logic        frst;
    } rd_exp_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    ad7606_emu_if bus();

    ad7606_emu #(.CONV_CYCLES(200), .NUM_CH(8)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int      total = 0;
    int      bad = 0;
    int      ign_cnt = 0;
    int      busy_len = 0;
    int      base;
    logic    oe_prev = 1'b0;
    logic    rd_pend = 1'b0;
    rd_exp_t rd_q[$];
    int      busy_q[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic wr_shadow(input logic [2:0] ch, input logic [15:0] val);
        bus.smp_wr   = 1'b1;
        bus.smp_ch   = ch;
        bus.smp_data = val;
        tick(1);
        bus.smp_wr   = 1'b0;
    endtask

    task automatic conv_pulse();
        bus.convst = 1'b1;
        tick(1);
        bus.convst = 1'b0;
    endtask

    task automatic start_conv(input logic [2:0] os_val, input int exp_len);
        bus.os = os_val;
        busy_q.push_back(exp_len);
        conv_pulse();
    endtask

    task automatic wait_done();
        int n = 0;
        while (bus.busy && n < 2000) begin
            tick(1);
            n++;
        end
        if (n >= 2000) check("busy_timeout", 1, 0);
        tick(2);
    endtask

    task automatic rd(input logic [15:0] exp_db, input logic exp_f);
        rd_q.push_back('{db: exp_db, frst: exp_f});
        bus.cs_n = 1'b0;
        bus.rd_n = 1'b0;
        tick(4);
        bus.rd_n = 1'b1;
        tick(1);
        bus.cs_n = 1'b1;
        tick(1);
    endtask

    task automatic rd_nocs(input logic [15:0] hold);
        bus.cs_n = 1'b1;
        bus.rd_n = 1'b0;
        tick(1);
        check("nocs_db_oe", bus.db_oe, 0);
        tick(3);
        bus.rd_n = 1'b1;
        tick(2);
        check("nocs_db_hold", bus.db, hold);
    endtask

    // Read monitor: every db_oe assertion owes one scoreboard entry, checked a cycle later.
    initial begin
        rd_exp_t e;
        forever begin
            @(negedge clk);
            if (rd_pend) begin
                rd_pend = 1'b0;
                if (rd_q.size() == 0) begin
                    check("rd_q_empty", 1, 0);
                end else begin
                    e = rd_q.pop_front();
                    check("rd_db", bus.db, e.db);
                    check("rd_frst", bus.frstdata, e.frst);
                end
            end
            if (bus.db_oe && !oe_prev) rd_pend = 1'b1;
            oe_prev = bus.db_oe;
        end
    end

    initial begin
        forever begin
            @(negedge clk);
            if (bus.conv_ignored) ign_cnt++;
            if (bus.busy) begin
                busy_len++;
            end else if (busy_len != 0) begin
                if (busy_q.size() == 0) check("busy_q_empty", 1, 0);
                else check("busy_len", busy_len, busy_q.pop_front());
                busy_len = 0;
            end
        end
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        bus.adc_rst  = 1'b0;
        bus.convst   = 1'b0;
        bus.cs_n     = 1'b1;
        bus.rd_n     = 1'b1;
        bus.os       = 3'd0;
        bus.smp_wr   = 1'b0;
        bus.smp_ch   = 3'd0;
        bus.smp_data = 16'h0000;
        tick(3);
        check("rst_busy", bus.busy, 0);
        check("rst_frst", bus.frstdata, 0);
        check("rst_db", bus.db, 16'h0000);
        check("rst_ign", bus.conv_ignored, 0);
        check("rst_db_oe", bus.db_oe, 0);
        rst_n = 1'b1;
        tick(2);

        for (int i = 0; i < 8; i++) wr_shadow(3'(i), 16'(16'h1111 * (i + 1)));
        start_conv(3'd0, 200);
        check("busy_rise", bus.busy, 1);
        wait_done();
        for (int i = 0; i < 8; i++) rd(16'(16'h1111 * (i + 1)), i == 0);
        rd(16'h1111, 1'b1);
        rd_nocs(16'h1111);
        rd(16'h2222, 1'b0);

        start_conv(3'd2, 800);
        wait_done();
        start_conv(3'd7, 200);
        tick(10);
        rd(16'h2222, 1'b0);
        wait_done();
        rd(16'h1111, 1'b1);

        base = ign_cnt;
        start_conv(3'd0, 200);
        tick(49);
        conv_pulse();
        wr_shadow(3'd0, 16'hABCD);
        wait_done();
        check("ign_once", ign_cnt - base, 1);
        rd(16'h1111, 1'b1);

        bus.os       = 3'd0;
        busy_q.push_back(200);
        bus.smp_wr   = 1'b1;
        bus.smp_ch   = 3'd1;
        bus.smp_data = 16'h5555;
        bus.convst   = 1'b1;
        tick(1);
        bus.convst   = 1'b0;
        bus.smp_wr   = 1'b0;
        wait_done();
        rd(16'hABCD, 1'b1);
        rd(16'h2222, 1'b0);

        base = ign_cnt;
        start_conv(3'd0, 100);
        tick(99);
        bus.adc_rst = 1'b1;
        tick(1);
        check("arst_busy", bus.busy, 0);
        check("arst_db", bus.db, 16'h0000);
        check("arst_frst", bus.frstdata, 0);
        conv_pulse();
        check("arst_conv_drop", bus.busy, 0);
        bus.adc_rst = 1'b0;
        tick(2);
        check("arst_still_idle", bus.busy, 0);
        check("arst_no_ign", ign_cnt - base, 0);
        rd(16'h0000, 1'b0);
        start_conv(3'd0, 200);
        wait_done();
        rd(16'hABCD, 1'b1);
        rd(16'h5555, 1'b0);

        tick(5);
        check("rd_q_left", rd_q.size(), 0);
        check("busy_q_left", busy_q.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
